// File: rtl/exception_handler_pkg.sv
// Shared definitions for the exception consumer: cause encodings, FSM states,
// counter widths and a saturating increment helper. Also used by the detector.
package exception_handler_pkg;

  localparam int unsigned CAUSE_W   = 3;
  localparam int unsigned EXC_CNT_W = 8;
  localparam int unsigned FCNT_W    = 3;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE   = 3'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_OPCODE = 3'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_FUNCT  = 3'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_REGDIR = 3'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_OVF    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    VECTOR  = 3'd2,
    HANDLER = 3'd3,
    RETURN  = 3'd4
  } exc_state_e;

  // Saturating increment for the exceptions-taken counter
  function automatic logic [EXC_CNT_W-1:0] sat_inc(input logic [EXC_CNT_W-1:0] v);
    return (v == {EXC_CNT_W{1'b1}}) ? v : v + EXC_CNT_W'(1);
  endfunction

endpackage

// File: rtl/exception_handler_exc_vector_gen.sv
// Handler vector computation from the latched cause.
// EXC_VECTORED_EN: when defined, each cause gets its own 4-word slot above HANDLER_BASE.
module exc_vector_gen
  import exception_handler_pkg::*;
#(
  parameter int unsigned           PC_WIDTH     = 6,
  parameter logic [PC_WIDTH-1:0]   HANDLER_BASE = PC_WIDTH'(32)
) (
  input  logic [CAUSE_W-1:0]  i_cause,
  output logic [PC_WIDTH-1:0] o_vector_c
);

`ifdef EXC_VECTORED_EN
  localparam bit VECTORED = 1'b1;
`else
  localparam bit VECTORED = 1'b0;
`endif

  localparam int unsigned SUM_W = PC_WIDTH + CAUSE_W + 2;

  logic [CAUSE_W+1:0] w_slot;
  logic [SUM_W-1:0]   w_sum;

  // Slot offset is cause*4; sum is taken wide and truncated to wrap modulo 2^PC_WIDTH
  always_comb begin
    w_slot     = {i_cause, 2'b00};
    w_sum      = SUM_W'(HANDLER_BASE) + SUM_W'(w_slot);
    o_vector_c = VECTORED ? PC_WIDTH'(w_sum) : HANDLER_BASE;
  end

endmodule

// File: rtl/exception_handler.sv
// Exception consumer: latches EPC/cause, flushes the pipeline, redirects fetch to
// the handler vector and back to EPC+PC_STEP on Eret. Vector mode: EXC_VECTORED_EN.
module exception_handler
  import exception_handler_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = 6,
  parameter int unsigned         FLUSH_CYCLES = 2,
  parameter logic [PC_WIDTH-1:0] HANDLER_BASE = PC_WIDTH'(32),
  parameter int unsigned         PC_STEP      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CAUSE_W-1:0]   ExceptionCause,
  input  logic [PC_WIDTH-1:0]  ExceptionPC,
  input  logic                 Eret,
  output logic                 ExcAck,
  output logic                 FlushIFID,
  output logic                 FlushIDEX,
  output logic                 FlushEXMEM,
  output logic                 PCWriteExc,
  output logic [PC_WIDTH-1:0]  ExcTarget,
  output logic [PC_WIDTH-1:0]  EPC,
  output logic [CAUSE_W-1:0]   CauseReg,
  output logic                 InHandler,
  output logic                 ExcLost,
  output logic [EXC_CNT_W-1:0] ExcCount
);

  exc_state_e            r_state;
  exc_state_e            w_state_nxt;
  logic [FCNT_W-1:0]     r_fcnt;
  logic [FCNT_W-1:0]     w_fcnt_nxt;
  logic                  w_accept;
  logic                  w_cause_hit;

  logic                  r_armed;
  logic [PC_WIDTH-1:0]   r_epc;
  logic [CAUSE_W-1:0]    r_cause;
  logic                  r_lost;
  logic [EXC_CNT_W-1:0]  r_count;
  logic                  r_ack;
  logic                  r_flush;
  logic                  r_pcw;
  logic [PC_WIDTH-1:0]   r_tgt;
  logic                  r_inh;

  logic [PC_WIDTH-1:0]   w_vector_c;
  logic [PC_WIDTH-1:0]   w_ret_target;
  logic [PC_WIDTH-1:0]   w_tgt_nxt;

  assign w_cause_hit  = (ExceptionCause != CAUSE_NONE);
  assign w_ret_target = r_epc + PC_WIDTH'(PC_STEP);

  exc_vector_gen #(
    .PC_WIDTH     (PC_WIDTH),
    .HANDLER_BASE (HANDLER_BASE)
  ) u_vector_gen (
    .i_cause    (r_cause),
    .o_vector_c (w_vector_c)
  );

  // FSM state and flush-length counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cause_hit && r_armed) begin
          w_accept    = 1'b1;
          w_fcnt_nxt  = FCNT_W'(FLUSH_CYCLES);
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (r_fcnt <= FCNT_W'(1)) begin
          w_state_nxt = VECTOR;
        end else begin
          w_fcnt_nxt = r_fcnt - FCNT_W'(1);
        end
      end
      VECTOR:  w_state_nxt = HANDLER;
      HANDLER: begin
        if (Eret) begin
          w_state_nxt = RETURN;
        end
      end
      RETURN:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Redirect target for the cycle being entered; zero when no redirect is issued
  always_comb begin
    w_tgt_nxt = '0;
    if (w_state_nxt == VECTOR) begin
      w_tgt_nxt = w_vector_c;
    end else if (w_state_nxt == RETURN) begin
      w_tgt_nxt = w_ret_target;
    end
  end

  // Outputs are registered from the next state so they align with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
      r_epc   <= '0;
      r_cause <= '0;
      r_lost  <= 1'b0;
      r_count <= '0;
      r_ack   <= 1'b0;
      r_flush <= 1'b0;
      r_pcw   <= 1'b0;
      r_tgt   <= '0;
      r_inh   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_epc   <= ExceptionPC;
        r_cause <= ExceptionCause;
        r_count <= sat_inc(r_count);
      end
      if (!w_cause_hit) begin
        r_armed <= 1'b1;
      end else if (w_accept) begin
        r_armed <= 1'b0;
      end
      if (w_cause_hit && (r_state != IDLE)) begin
        r_lost <= 1'b1;
      end
      r_ack   <= w_accept;
      r_flush <= (w_state_nxt == FLUSH);
      r_pcw   <= (w_state_nxt == VECTOR) || (w_state_nxt == RETURN);
      r_tgt   <= w_tgt_nxt;
      r_inh   <= (w_state_nxt == HANDLER);
    end
  end

  assign ExcAck     = r_ack;
  assign FlushIFID  = r_flush;
  assign FlushIDEX  = r_flush;
  assign FlushEXMEM = r_flush;
  assign PCWriteExc = r_pcw;
  assign ExcTarget  = r_tgt;
  assign EPC        = r_epc;
  assign CauseReg   = r_cause;
  assign InHandler  = r_inh;
  assign ExcLost    = r_lost;
  assign ExcCount   = r_count;

endmodule

// File: doc/exception_handler.md
# exception_handler

Consumer side of the pipeline exception protocol. Samples the cause/PC pair raised by the exception detection logic and latches them into EPC and Cause registers. Flushes the pipeline and redirects fetch to the handler vector, then waits in handler mode until an exception-return request. On return, fetch restarts at the instruction after the faulting one. Sits between the exception detection unit and the PC-select / pipeline-register flush logic.

## Interface
- PC_WIDTH, 6, width of PC and all PC-valued ports
- FLUSH_CYCLES, 2, cycles the flush outputs stay asserted (1..7)
- HANDLER_BASE, 6'd32, handler entry address
- PC_STEP, 1, increment applied to EPC on return

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ExceptionCause  in  3  0 = none; 1 opcode, 2 function, 3 register, 4 overflow
- ExceptionPC  in  PC_WIDTH  PC of the faulting instruction
- Eret  in  1  exception-return request, level, sampled only in HANDLER
- ExcAck  out  1  one-cycle pulse, tells the detector to clear its cause
- FlushIFID, FlushIDEX, FlushEXMEM  out  1 each  pipeline-register flush
- PCWriteExc  out  1  overrides normal PC select for one cycle
- ExcTarget  out  PC_WIDTH  PC loaded when PCWriteExc=1
- EPC  out  PC_WIDTH  latched exception PC
- CauseReg  out  3  latched cause
- InHandler  out  1  high while in HANDLER
- ExcLost  out  1  sticky; an exception arrived while not in IDLE
- ExcCount  out  8  saturating count of exceptions taken

## Operation
- All outputs are registered (Moore).
- Reset value of every output is 0. After reset, state=IDLE and armed=1.
- FSM states:
  - IDLE: if ExceptionCause≠0 and armed, accept the exception:
    - EPC←ExceptionPC, CauseReg←ExceptionCause
    - armed←0, ExcCount←min(ExcCount+1,255)
    - flush counter←FLUSH_CYCLES, go to FLUSH
  - FLUSH: all three flush outputs =1; counter decrements each cycle; at 1 go to VECTOR.
  - VECTOR: PCWriteExc=1, ExcTarget=vector; go to HANDLER.
  - HANDLER: InHandler=1; Eret=1 → go to RETURN.
  - RETURN: PCWriteExc=1, ExcTarget=(EPC+PC_STEP) mod 2^PC_WIDTH; go to IDLE.
- ExcAck is 1 only in the first FLUSH cycle.
- Re-arm: armed←1 whenever ExceptionCause==0 is sampled in any state. A cause held nonzero across a return is not retaken.
- ExceptionCause≠0 while state≠IDLE:
  - ExcLost←1; EPC and CauseReg unchanged.
  - ExcLost clears only on reset.
- Eret outside HANDLER is ignored.
- Cause values 5–7 are accepted and latched unchanged.
- PC arithmetic is modulo 2^PC_WIDTH, with no overflow flag.

## Timing
- Cause sampled at edge k → EPC/CauseReg valid and state=FLUSH after edge k; ExcAck high for cycle k+1 only.
- Flush outputs high for cycles k+1 … k+FLUSH_CYCLES.
- PCWriteExc high for cycle k+FLUSH_CYCLES+1.
- InHandler rises at cycle k+FLUSH_CYCLES+2.
- Eret sampled at edge m in HANDLER → InHandler low and PCWriteExc high for cycle m+1; state=IDLE at m+2.
- Minimum turnaround from acceptance back to IDLE: FLUSH_CYCLES+3 cycles.
- Reset mid-operation: all outputs go to 0 asynchronously; no partial redirect is issued after release.

## Configuration
- EXC_VECTORED_EN defined: vector = (HANDLER_BASE + {CauseReg,2'b00}) mod 2^PC_WIDTH, i.e. a 4-word slot per cause.
- EXC_VECTORED_EN undefined: vector = HANDLER_BASE for every cause.

## Structure
- Shared package holds:
  - cause encodings: CAUSE_NONE=0, CAUSE_OPCODE=1, CAUSE_FUNCT=2, CAUSE_REGDIR=3, CAUSE_OVF=4
  - FSM state typedef: IDLE, FLUSH, VECTOR, HANDLER, RETURN
  - ExcCount width constant (8)
  - The detector uses the same cause encodings.
- One natural sub-module, exc_vector_gen: combinational vector computation from CauseReg and HANDLER_BASE. It is the only place EXC_VECTORED_EN is tested.

## Test plan
- Reset, then cause=4, ExceptionPC=12:
  - EPC=12, CauseReg=4, ExcAck pulses once
  - flushes high for 2 cycles
  - PCWriteExc with ExcTarget=48 (vectored) or 32 (non-vectored)
  - InHandler=1, ExcCount=1
- In HANDLER, Eret=1 with EPC=12 → one cycle of PCWriteExc with ExcTarget=13; InHandler=0; IDLE two cycles later.
- Cause=2, PC=7 arrives while in HANDLER → ExcLost=1; EPC=12 and CauseReg=4 unchanged; no flush.
- Cause held at 4 through return → no second acceptance. Drop cause to 0 for one cycle, then cause=1, PC=20 → accepted, EPC=20, ExcCount=2.
- EPC=63 return with PC_STEP=1 → ExcTarget=0 (wrap).
- rst_n low during the second FLUSH cycle → all outputs 0 immediately. After release, no PCWriteExc pulse; state=IDLE, armed.
